// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and constants shared by the multiply/divide unit
package muldiv_pkg;
    localparam int XLEN  = 32;
    localparam int ITERS = 32;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [4:0] ALU_MUL    = 5'b01000;
    localparam logic [4:0] ALU_MULH   = 5'b01001;
    localparam logic [4:0] ALU_MULHSU = 5'b01010;
    localparam logic [4:0] ALU_MULHU  = 5'b01011;
    localparam logic [4:0] ALU_DIV    = 5'b01100;
    localparam logic [4:0] ALU_DIVU   = 5'b01101;
    localparam logic [4:0] ALU_REM    = 5'b01110;
    localparam logic [4:0] ALU_REMU   = 5'b01111;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result handshake between the execute stage and the multiply/divide unit
interface muldiv_if import muldiv_pkg::*; ();
    logic            start_i;
    logic            flush_i;
    logic [4:0]      alu_op_i;
    logic [XLEN-1:0] op_a_i;
    logic [XLEN-1:0] op_b_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (output start_i, flush_i, alu_op_i, op_a_i, op_b_i,
                    input  busy_o, done_o, result_o);
    modport slave  (input  start_i, flush_i, alu_op_i, op_a_i, op_b_i,
                    output busy_o, done_o, result_o);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: operand magnitudes / negate flags on entry, sign restoration and word select on exit
module muldiv_sign_fix import muldiv_pkg::*; (
    input  logic [4:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_lo_o,
    output logic              neg_hi_o,
    input  logic [4:0]        fix_op_i,
    input  logic              fix_neg_lo_i,
    input  logic              fix_neg_hi_i,
    input  logic [2*XLEN-1:0] acc_i,
    output logic [XLEN-1:0]   result_o
);
    logic            sa, sb;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem;

    // MUL uses unsigned magnitudes: its low word is identical for any signedness
    always_comb begin
        sa       = a_i[XLEN-1] && (op_i == ALU_MULH || op_i == ALU_MULHSU || op_i == ALU_DIV || op_i == ALU_REM);
        sb       = b_i[XLEN-1] && (op_i == ALU_MULH || op_i == ALU_DIV || op_i == ALU_REM);
        mag_a_o  = sa ? -a_i : a_i;
        mag_b_o  = sb ? -b_i : b_i;
        neg_lo_o = sa ^ sb;
        neg_hi_o = sa;
        prod     = fix_neg_lo_i ? -acc_i : acc_i;
        quo      = fix_neg_lo_i ? -acc_i[XLEN-1:0] : acc_i[XLEN-1:0];
        rem      = fix_neg_hi_i ? -acc_i[2*XLEN-1:XLEN] : acc_i[2*XLEN-1:XLEN];
        result_o = fix_op_i[2] ? (fix_op_i[1] ? rem : quo)
                 : (fix_op_i[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide with start/busy/done handshake
module muldiv_unit import muldiv_pkg::*; (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    state_t            state, state_n;
    logic [4:0]        cnt;
    logic [4:0]        op_q;
    logic              neg_lo_q, neg_hi_q;
    logic [XLEN-1:0]   b_q, mag_a, mag_b, fix_res, special_res, sub, result_q;
    logic [2*XLEN-1:0] acc, acc_n;
    logic [XLEN:0]     sum, r_sh;
    logic              neg_lo, neg_hi, accept, div_zero, div_ovf, ge, last;

    muldiv_sign_fix u_sign_fix (
        .op_i         (bus.alu_op_i),
        .a_i          (bus.op_a_i),
        .b_i          (bus.op_b_i),
        .mag_a_o      (mag_a),
        .mag_b_o      (mag_b),
        .neg_lo_o     (neg_lo),
        .neg_hi_o     (neg_hi),
        .fix_op_i     (op_q),
        .fix_neg_lo_i (neg_lo_q),
        .fix_neg_hi_i (neg_hi_q),
        .acc_i        (acc_n),
        .result_o     (fix_res)
    );

    assign bus.busy_o   = state == CALC;
    assign bus.done_o   = state == DONE && !bus.flush_i;
    assign bus.result_o = result_q;

    // acc holds {hi, lo}: product high/low for multiply, {remainder, quotient} for divide
    always_comb begin
        accept      = state == IDLE && bus.start_i && !bus.flush_i && bus.alu_op_i[4:3] == 2'b01;
        div_zero    = bus.alu_op_i[2] && bus.op_b_i == '0;
        div_ovf     = (bus.alu_op_i == ALU_DIV || bus.alu_op_i == ALU_REM) && bus.op_a_i == MIN_INT && bus.op_b_i == '1;
        special_res = div_zero ? (bus.alu_op_i[1] ? bus.op_a_i : '1) : (bus.alu_op_i[1] ? '0 : MIN_INT);
        sum         = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
        r_sh        = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        ge          = r_sh >= {1'b0, b_q};
        sub         = r_sh[XLEN-1:0] - b_q;
        acc_n       = op_q[2] ? {(ge ? sub : r_sh[XLEN-1:0]), acc[XLEN-2:0], ge} : {sum, acc[XLEN-1:1]};
        last        = cnt == 5'(ITERS - 1);
        state_n     = state == IDLE ? (accept ? ((div_zero || div_ovf) ? DONE : CALC) : IDLE)
                    : state == CALC ? (bus.flush_i ? IDLE : (last ? DONE : CALC))
                    : IDLE;
    end

    // FSM state, iteration counter and datapath registers; result written on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            b_q      <= '0;
            acc      <= '0;
            result_q <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q     <= bus.alu_op_i;
                neg_lo_q <= neg_lo;
                neg_hi_q <= neg_hi;
                b_q      <= mag_b;
                acc      <= {{XLEN{1'b0}}, mag_a};
                cnt      <= '0;
                if (div_zero || div_ovf)
                    result_q <= special_res;
            end else if (state == CALC) begin
                acc <= acc_n;
                cnt <= cnt + 5'd1;
                if (last && !bus.flush_i)
                    result_q <= fix_res;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table plus hand-written control sequences for muldiv_unit
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    muldiv_if bus ();
    muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_n,
                          output logic busy_at_done, output logic done_after);
        bus.alu_op_i = op;
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat    = 1;
        busy_n = 0;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            if (bus.busy_o === 1'b1) busy_n++;
            @(posedge clk);
            #1 lat++;
        end
        res          = bus.result_o;
        busy_at_done = bus.busy_o;
        @(posedge clk);
        #1 done_after = bus.done_o;
    endtask

    task automatic count_cycles(input int n, output int dones, output int busies);
        dones  = 0;
        busies = 0;
        for (int i = 0; i < n; i++) begin
            if (bus.done_o === 1'b1) dones++;
            if (bus.busy_o === 1'b1) busies++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [31:0] res;
        int          lat, busy_n, dones, busies;
        logic        busy_at_done, done_after;

        vecs[0]  = '{"mul_7_m3",       ALU_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{"mulhu_max",      ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{"mulh_min_m1",    ALU_MULH,   32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{"mulhsu_min_max", ALU_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
        vecs[4]  = '{"div_m7_2",       ALU_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
        vecs[5]  = '{"rem_m7_2",       ALU_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
        vecs[6]  = '{"divu_100_7",     ALU_DIVU,   32'd100,        32'd7,         32'd14,        33};
        vecs[7]  = '{"remu_100_7",     ALU_REMU,   32'd100,        32'd7,         32'd2,         33};
        vecs[8]  = '{"div_20_m7",      ALU_DIV,    32'd20,         32'hFFFF_FFF9, 32'hFFFF_FFFE, 33};
        vecs[9]  = '{"rem_20_m7",      ALU_REM,    32'd20,         32'hFFFF_FFF9, 32'd6,         33};
        vecs[10] = '{"mul_big",        ALU_MUL,    32'h0001_0003,  32'h0002_0005, 32'h000B_000F, 33};
        vecs[11] = '{"mulh_m2_3",      ALU_MULH,   32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF, 33};
        vecs[12] = '{"divu_by_0",      ALU_DIVU,   32'h0001_2345,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{"rem_by_0",       ALU_REM,    32'h0001_2345,  32'd0,         32'h0001_2345, 1};
        vecs[14] = '{"div_ovf",        ALU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[15] = '{"rem_ovf",        ALU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1};

        bus.start_i  = 1'b0;
        bus.flush_i  = 1'b0;
        bus.alu_op_i = '0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, bus.busy_o}, 32'd0);
        check("reset_done", {31'd0, bus.done_o}, 32'd0);
        check("reset_result", bus.result_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, busy_n, busy_at_done, done_after);
            check({vecs[i].name, "_result"}, res, vecs[i].res);
            check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
            check({vecs[i].name, "_busy_cycles"}, busy_n, vecs[i].lat == 33 ? 32 : 0);
            check({vecs[i].name, "_busy_at_done"}, {31'd0, busy_at_done}, 32'd0);
            check({vecs[i].name, "_done_pulse"}, {31'd0, done_after}, 32'd0);
        end

        run_op(ALU_MUL, 32'd3, 32'd5, res, lat, busy_n, busy_at_done, done_after);
        check("pre_flush_result", res, 32'd15);
        bus.alu_op_i = ALU_MUL;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'd9;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("flush_busy_before", {31'd0, bus.busy_o}, 32'd1);
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        check("flush_busy_after", {31'd0, bus.busy_o}, 32'd0);
        count_cycles(40, dones, busies);
        check("flush_no_done", dones, 0);
        check("flush_no_busy", busies, 0);
        check("flush_result_kept", bus.result_o, 32'd15);

        bus.alu_op_i = ALU_DIVU;
        bus.op_a_i   = 32'd100;
        bus.op_b_i   = 32'd7;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.alu_op_i = ALU_MUL;
        bus.op_a_i   = 32'd3;
        bus.op_b_i   = 32'd3;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        lat = 6;
        while (bus.done_o !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1 lat++;
        end
        check("busy_start_latency", lat, 33);
        check("busy_start_result", bus.result_o, 32'd14);
        @(posedge clk);
        #1;
        count_cycles(40, dones, busies);
        check("busy_start_no_second_done", dones, 0);
        check("busy_start_no_second_busy", busies, 0);

        bus.alu_op_i = 5'b00000;
        bus.op_a_i   = 32'd5;
        bus.op_b_i   = 32'd6;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        count_cycles(40, dones, busies);
        check("bad_op_no_done", dones, 0);
        check("bad_op_no_busy", busies, 0);
        check("bad_op_result_kept", bus.result_o, 32'd14);

        bus.alu_op_i = ALU_MUL;
        bus.start_i  = 1'b1;
        bus.flush_i  = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        count_cycles(40, dones, busies);
        check("idle_flush_no_done", dones, 0);
        check("idle_flush_no_busy", busies, 0);

        bus.alu_op_i = ALU_MUL;
        bus.op_a_i   = 32'd7;
        bus.op_b_i   = 32'd9;
        bus.start_i  = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
        check("rst_done", {31'd0, bus.done_o}, 32'd0);
        check("rst_result", bus.result_o, 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        count_cycles(40, dones, busies);
        check("rst_no_done", dones, 0);
        check("rst_no_busy", busies, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
